// File: rtl/sram_like_arbiter.sv
// Two-to-one arbiter sharing a single SRAM-like master port between an instruction
// port and a data port, with at most one transaction outstanding at any time.
module sram_like_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        i_req,
    input  logic        i_wr,
    input  logic [1:0]  i_size,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] i_rdata,
    output logic        i_addr_ok,
    output logic        i_data_ok,

    input  logic        d_req,
    input  logic        d_wr,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_addr_ok,
    output logic        d_data_ok,

    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok
);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t state;
    state_t state_next;
    logic   owner;
    logic   last;
    logic   any_req;
    logic   sel_data;
    logic   accept;

    assign any_req = i_req | d_req;
    assign accept  = (state == IDLE) && any_req && m_addr_ok && !rst;

    // On contention the round-robin mode hands the grant to whichever port did not win last.
    always_comb begin
        sel_data = 1'b0;
        if (d_req && !i_req) begin
            sel_data = 1'b1;
        end else if (d_req && i_req) begin
            sel_data = RR_EN ? ~last : 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            owner <= 1'b0;
            last  <= 1'b1;
        end else begin
            state <= state_next;
            if (accept) begin
                owner <= sel_data;
                last  <= sel_data;
            end
        end
    end

    // Outputs are held quiet during reset so a response pending in WAIT is never forwarded.
    always_comb begin
        state_next = state;
        m_req      = 1'b0;
        m_wr       = 1'b0;
        m_size     = 2'b00;
        m_addr     = 32'h0;
        m_wdata    = 32'h0;
        i_addr_ok  = 1'b0;
        d_addr_ok  = 1'b0;
        i_data_ok  = 1'b0;
        d_data_ok  = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        m_req = 1'b1;
                        if (sel_data) begin
                            m_wr      = d_wr;
                            m_size    = d_size;
                            m_addr    = d_addr;
                            m_wdata   = d_wdata;
                            d_addr_ok = m_addr_ok;
                        end else begin
                            m_wr      = i_wr;
                            m_size    = i_size;
                            m_addr    = i_addr;
                            m_wdata   = i_wdata;
                            i_addr_ok = m_addr_ok;
                        end
                        if (m_addr_ok) begin
                            state_next = WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (m_data_ok) begin
                        i_data_ok  = ~owner;
                        d_data_ok  = owner;
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Scoreboard bench for sram_like_arbiter: one round-robin and one fixed-priority
// instance share stimulus; a small master model answers the selected instance.
module tb_sram_like_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        i_req, i_wr, d_req, d_wr;
    logic [1:0]  i_size, d_size;
    logic [31:0] i_addr, i_wdata, d_addr, d_wdata;
    logic [31:0] m_rdata;
    logic        m_addr_ok, m_data_ok;

    logic [31:0] rr_i_rdata, rr_d_rdata, rr_m_addr, rr_m_wdata;
    logic        rr_i_addr_ok, rr_i_data_ok, rr_d_addr_ok, rr_d_data_ok, rr_m_req, rr_m_wr;
    logic [1:0]  rr_m_size;
    logic [31:0] fp_i_rdata, fp_d_rdata, fp_m_addr, fp_m_wdata;
    logic        fp_i_addr_ok, fp_i_data_ok, fp_d_addr_ok, fp_d_data_ok, fp_m_req, fp_m_wr;
    logic [1:0]  fp_m_size;

    sram_like_arbiter #(.RR_EN(1'b1)) dut_rr (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_wr(i_wr), .i_size(i_size), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_rdata(rr_i_rdata), .i_addr_ok(rr_i_addr_ok), .i_data_ok(rr_i_data_ok),
        .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(rr_d_rdata), .d_addr_ok(rr_d_addr_ok), .d_data_ok(rr_d_data_ok),
        .m_req(rr_m_req), .m_wr(rr_m_wr), .m_size(rr_m_size), .m_addr(rr_m_addr),
        .m_wdata(rr_m_wdata), .m_rdata(m_rdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok)
    );

    sram_like_arbiter #(.RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_wr(i_wr), .i_size(i_size), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_rdata(fp_i_rdata), .i_addr_ok(fp_i_addr_ok), .i_data_ok(fp_i_data_ok),
        .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(fp_d_rdata), .d_addr_ok(fp_d_addr_ok), .d_data_ok(fp_d_data_ok),
        .m_req(fp_m_req), .m_wr(fp_m_wr), .m_size(fp_m_size), .m_addr(fp_m_addr),
        .m_wdata(fp_m_wdata), .m_rdata(m_rdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok)
    );

    logic        use_fp;
    logic [31:0] s_i_rdata, s_d_rdata, s_m_addr, s_m_wdata;
    logic        s_i_addr_ok, s_i_data_ok, s_d_addr_ok, s_d_data_ok, s_m_req, s_m_wr;
    logic [1:0]  s_m_size;

    always_comb begin
        s_i_rdata = rr_i_rdata;   s_d_rdata = rr_d_rdata;
        s_m_addr  = rr_m_addr;    s_m_wdata = rr_m_wdata;
        s_i_addr_ok = rr_i_addr_ok; s_i_data_ok = rr_i_data_ok;
        s_d_addr_ok = rr_d_addr_ok; s_d_data_ok = rr_d_data_ok;
        s_m_req = rr_m_req; s_m_wr = rr_m_wr; s_m_size = rr_m_size;
        if (use_fp) begin
            s_i_rdata = fp_i_rdata;   s_d_rdata = fp_d_rdata;
            s_m_addr  = fp_m_addr;    s_m_wdata = fp_m_wdata;
            s_i_addr_ok = fp_i_addr_ok; s_i_data_ok = fp_i_data_ok;
            s_d_addr_ok = fp_d_addr_ok; s_d_data_ok = fp_d_data_ok;
            s_m_req = fp_m_req; s_m_wr = fp_m_wr; s_m_size = fp_m_size;
        end
    end

    typedef struct {
        logic        port;
        logic [31:0] addr;
        logic [31:0] rdata;
    } txn_t;

    txn_t grant_q[$];
    txn_t resp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic        pending;
    logic [31:0] pending_addr;

    function automatic logic [31:0] rdataFor(input logic [31:0] addr);
        return addr ^ 32'h5A5A_0F0F;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic ireq, input logic dreq);
        i_req = ireq;
        d_req = dreq;
    endtask

    task automatic pushTxn(input logic port, input logic [31:0] addr, input logic [31:0] rdata);
        txn_t t;
        t.port = port; t.addr = addr; t.rdata = rdata;
        grant_q.push_back(t);
        resp_q.push_back(t);
    endtask

    task automatic driveMaster(input logic addr_ok);
        m_addr_ok = addr_ok;
        m_data_ok = pending;
        m_rdata   = pending ? rdataFor(pending_addr) : 32'h0;
    endtask

    // Pops the scoreboard whenever an addr_ok or data_ok appears on either port.
    task automatic observe();
        txn_t t;
        checkOutput("addr_ok_excl", 32'(s_i_addr_ok & s_d_addr_ok), 32'd0);
        checkOutput("data_ok_excl", 32'(s_i_data_ok & s_d_data_ok), 32'd0);
        if (s_i_addr_ok || s_d_addr_ok) begin
            if (grant_q.size() == 0) begin
                checkOutput("grant_unexp", 32'(s_i_addr_ok | s_d_addr_ok), 32'd0);
            end else begin
                t = grant_q.pop_front();
                checkOutput("grant_port", 32'(s_d_addr_ok), 32'(t.port));
                checkOutput("grant_addr", s_m_addr, t.addr);
            end
        end
        if (s_i_data_ok || s_d_data_ok) begin
            if (resp_q.size() == 0) begin
                checkOutput("resp_unexp", 32'(s_i_data_ok | s_d_data_ok), 32'd0);
            end else begin
                t = resp_q.pop_front();
                checkOutput("resp_port", 32'(s_d_data_ok), 32'(t.port));
                checkOutput("resp_rdata", s_d_data_ok ? s_d_rdata : s_i_rdata, t.rdata);
            end
        end
    endtask

    task automatic finishCycle();
        if (s_m_req && m_addr_ok) begin
            pending      = 1'b1;
            pending_addr = s_m_addr;
        end else if (m_data_ok) begin
            pending = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic queuesEmpty(input string tag);
        checkOutput({tag, "_grants_left"}, 32'(grant_q.size()), 32'd0);
        checkOutput({tag, "_resps_left"}, 32'(resp_q.size()), 32'd0);
        grant_q.delete();
        resp_q.delete();
    endtask

    // Requests and master handshakes are held high through reset; nothing may leak out.
    task automatic doReset(input logic fp);
        use_fp = fp;
        rst = 1'b1;
        applyStimulus(1'b1, 1'b1);
        m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = 32'hDEAD_BEEF;
        #1;
        checkOutput("rst_m_req", 32'(s_m_req), 32'd0);
        checkOutput("rst_i_addr_ok", 32'(s_i_addr_ok), 32'd0);
        checkOutput("rst_d_addr_ok", 32'(s_d_addr_ok), 32'd0);
        checkOutput("rst_i_data_ok", 32'(s_i_data_ok), 32'd0);
        checkOutput("rst_d_data_ok", 32'(s_d_data_ok), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0);
        m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = 32'h0;
        pending = 1'b0; pending_addr = 32'h0;
    endtask

    task automatic contention(input logic fp, input string tag);
        doReset(fp);
        i_addr = 32'h0000_1000; i_wr = 1'b0; i_size = 2'b10; i_wdata = 32'h0;
        d_addr = 32'h0000_2000; d_wr = 1'b0; d_size = 2'b10; d_wdata = 32'h0;
        for (int k = 0; k < 4; k++) begin
            if (fp || k % 2 == 1) pushTxn(1'b1, d_addr, rdataFor(d_addr));
            else                  pushTxn(1'b0, i_addr, rdataFor(i_addr));
        end
        for (int c = 0; c < 8; c++) begin
            applyStimulus(1'b1, 1'b1);
            driveMaster(1'b1);
            #1;
            observe();
            if (fp) checkOutput({tag, "_i_addr_ok"}, 32'(s_i_addr_ok), 32'd0);
            finishCycle();
        end
        applyStimulus(1'b0, 1'b0);
        driveMaster(1'b1);
        #1;
        observe();
        finishCycle();
        queuesEmpty(tag);
    endtask

    initial begin
        use_fp = 1'b0;
        i_wr = 1'b0; i_size = 2'b00; i_addr = 32'h0; i_wdata = 32'h0;
        d_wr = 1'b0; d_size = 2'b00; d_addr = 32'h0; d_wdata = 32'h0;

        // Single instruction fetch with a two-cycle response latency.
        doReset(1'b0);
        #1;
        checkOutput("idle_m_req", 32'(s_m_req), 32'd0);
        checkOutput("idle_m_addr", s_m_addr, 32'h0);
        checkOutput("idle_m_wdata", s_m_wdata, 32'h0);
        i_addr = 32'hBFC0_0000; i_wr = 1'b0; i_size = 2'b10;
        pushTxn(1'b0, 32'hBFC0_0000, 32'h3C08_0000);
        applyStimulus(1'b1, 1'b0);
        driveMaster(1'b1);
        #1;
        checkOutput("s1_i_addr_ok", 32'(s_i_addr_ok), 32'd1);
        checkOutput("s1_d_data_ok", 32'(s_d_data_ok), 32'd0);
        observe();
        finishCycle();
        applyStimulus(1'b0, 1'b0);
        driveMaster(1'b0);
        m_data_ok = 1'b0;
        #1;
        checkOutput("s1_wait_m_req", 32'(s_m_req), 32'd0);
        checkOutput("s1_d_data_ok", 32'(s_d_data_ok), 32'd0);
        observe();
        finishCycle();
        driveMaster(1'b0);
        m_rdata = 32'h3C08_0000;
        #1;
        checkOutput("s1_i_data_ok", 32'(s_i_data_ok), 32'd1);
        checkOutput("s1_d_data_ok", 32'(s_d_data_ok), 32'd0);
        observe();
        finishCycle();
        driveMaster(1'b0);
        #1;
        checkOutput("s1_i_data_ok_drop", 32'(s_i_data_ok), 32'd0);
        observe();
        finishCycle();
        queuesEmpty("s1");

        // Data write stalled by the master for three cycles.
        doReset(1'b0);
        d_wr = 1'b1; d_size = 2'b01; d_addr = 32'h8000_0002; d_wdata = 32'h0000_BEEF;
        pushTxn(1'b1, 32'h8000_0002, rdataFor(32'h8000_0002));
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b0, 1'b1);
            driveMaster(c == 3);
            #1;
            checkOutput("s4_m_req", 32'(s_m_req), 32'd1);
            checkOutput("s4_m_wr", 32'(s_m_wr), 32'd1);
            checkOutput("s4_m_size", 32'(s_m_size), 32'd1);
            checkOutput("s4_m_addr", s_m_addr, 32'h8000_0002);
            checkOutput("s4_m_wdata", s_m_wdata, 32'h0000_BEEF);
            checkOutput("s4_d_addr_ok", 32'(s_d_addr_ok), 32'(c == 3));
            observe();
            finishCycle();
        end
        applyStimulus(1'b0, 1'b0);
        driveMaster(1'b0);
        #1;
        observe();
        finishCycle();
        queuesEmpty("s4");

        contention(1'b0, "s2_rr");
        contention(1'b1, "s3_fp");

        // Reset asserted while a fetch is outstanding drops its response.
        doReset(1'b0);
        i_addr = 32'h0000_0040; i_wr = 1'b0; i_size = 2'b10;
        pushTxn(1'b0, 32'h0000_0040, 32'h0);
        applyStimulus(1'b1, 1'b0);
        driveMaster(1'b1);
        #1;
        observe();
        finishCycle();
        applyStimulus(1'b0, 1'b0);
        rst = 1'b1;
        m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = 32'h1234_5678;
        #1;
        checkOutput("s5_rst_i_data_ok", 32'(s_i_data_ok), 32'd0);
        checkOutput("s5_rst_d_data_ok", 32'(s_d_data_ok), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_data_ok = 1'b1;
        #1;
        checkOutput("s5_i_data_ok", 32'(s_i_data_ok), 32'd0);
        checkOutput("s5_d_data_ok", 32'(s_d_data_ok), 32'd0);
        @(posedge clk);
        #1;
        m_data_ok = 1'b0;
        applyStimulus(1'b1, 1'b0);
        #1;
        checkOutput("s5_idle_m_req", 32'(s_m_req), 32'd1);
        @(posedge clk);
        #1;
        resp_q.delete();
        queuesEmpty("s5");

        // Stray m_data_ok in IDLE is ignored.
        doReset(1'b0);
        applyStimulus(1'b0, 1'b0);
        m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = 32'hCAFE_F00D;
        #1;
        checkOutput("s6_i_data_ok", 32'(s_i_data_ok), 32'd0);
        checkOutput("s6_d_data_ok", 32'(s_d_data_ok), 32'd0);
        checkOutput("s6_m_req", 32'(s_m_req), 32'd0);
        @(posedge clk);
        #1;
        m_data_ok = 1'b0;
        applyStimulus(1'b0, 1'b1);
        #1;
        checkOutput("s6_idle_m_req", 32'(s_m_req), 32'd1);
        checkOutput("s6_i_data_ok_after", 32'(s_i_data_ok), 32'd0);
        @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
